// File: rtl/bmc_pulse_decoder.sv
// bmc_pulse_decoder
//   Decodes the biphase-mark (BMC) bit stream carried inside each Lighthouse
//   light pulse seen on one sensor face. Each decoded bit produces a 1-cycle
//   strobe. Pulse start is timestamped, and a per-pulse summary (bit count and
//   error flag) is reported when the pulse ends.
//
// Ports
//   clk_96MHz    in   system clock
//   reset_n      in   synchronous reset, active low
//   d_in_first   in   newest registered data sample
//   d_in_second  in   data sample one cycle older than d_in_first
//   e_in         in   registered envelope sample
//   bit_out      out  decoded bit value, valid with bit_valid
//   bit_valid    out  1-cycle strobe per decoded bit
//   pulse_active out  high from pulse start to pulse end
//   pulse_start  out  1-cycle strobe on envelope activation
//   start_ts     out  timestamp latched at pulse start
//   pulse_end    out  1-cycle strobe on envelope deactivation
//   bit_count    out  bits decoded in the pulse (saturating), valid with pulse_end
//   pulse_error  out  glitch/timeout/bad-phase seen in the pulse, valid with pulse_end
//
// FSM state is held in state_q (type state_t) for checker binding.
// No valid/ready handshake: outputs are strobes the consumer must sample.
module bmc_pulse_decoder #(
  parameter logic ENV_ACTIVE = 1'b0,
  parameter int   HALF_MIN   = 4,
  parameter int   HALF_MAX   = 11,
  parameter int   FULL_MAX   = 23,
  parameter int   TS_WIDTH   = 32,
  parameter int   CNT_WIDTH  = 8
) (
  input  logic                 clk_96MHz,
  input  logic                 reset_n,
  input  logic                 d_in_first,
  input  logic                 d_in_second,
  input  logic                 e_in,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 pulse_active,
  output logic                 pulse_start,
  output logic [TS_WIDTH-1:0]  start_ts,
  output logic                 pulse_end,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic                 pulse_error
);

  // Interval counter only needs to reach FULL_MAX+1 (its saturation value).
  localparam int IW = $clog2(FULL_MAX + 2);
  localparam logic [IW-1:0]        HMIN    = IW'(HALF_MIN);
  localparam logic [IW-1:0]        HMAX    = IW'(HALF_MAX);
  localparam logic [IW-1:0]        FMAX    = IW'(FULL_MAX);
  localparam logic [IW-1:0]        TOUT    = IW'(FULL_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DECODE,
    S_HALF,
    S_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [IW-1:0]         int_q, int_d;
  logic                  env_prev_q, env_prev_d;
  logic [TS_WIDTH-1:0]   start_ts_q, start_ts_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  active_q, active_d;
  logic                  pstart_q, pstart_d;
  logic                  pend_q, pend_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  bit_out_q, bit_out_d;

  logic data_edge, env_on, env_rise, env_fall;
  logic emit, emit_val, timeout;

  always_comb begin
    data_edge = d_in_first ^ d_in_second;
    env_on    = (e_in == ENV_ACTIVE);
    env_rise  = env_on & ~env_prev_q;
    env_fall  = ~env_on & env_prev_q;
    timeout   = (int_q > FMAX);

    state_d     = state_q;
    ts_d        = ts_q + 1'b1;
    int_d       = data_edge ? IW'(1) : ((int_q >= TOUT) ? TOUT : int_q + 1'b1);
    env_prev_d  = env_on;
    start_ts_d  = start_ts_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    active_d    = active_q;
    pstart_d    = 1'b0;
    pend_d      = 1'b0;
    bit_valid_d = 1'b0;
    bit_out_d   = 1'b0;
    emit        = 1'b0;
    emit_val    = 1'b0;

    if (env_fall) begin
      // Envelope loss has priority over any data edge in the same cycle.
      state_d = S_IDLE;
      if (active_q) begin
        pend_d   = 1'b1;
        active_d = 1'b0;
        if (state_q == S_HALF) err_d = 1'b1;  // dangling half bit
      end
    end else if (env_rise) begin
      pstart_d   = 1'b1;
      start_ts_d = ts_q;
      active_d   = 1'b1;
      cnt_d      = '0;
      err_d      = 1'b0;
      state_d    = S_SYNC;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (data_edge) state_d = S_DECODE;
        end
        S_DECODE: begin
          if (data_edge && !timeout) begin
            if (int_q < HMIN) begin
              err_d   = 1'b1;
              state_d = S_FLUSH;
            end else if (int_q <= HMAX) begin
              state_d = S_HALF;
            end else begin
              emit     = 1'b1;
              emit_val = 1'b0;
            end
          end else if (timeout) begin
            // Long silence after data is just end of data.
            state_d = S_FLUSH;
            if (cnt_q == '0) err_d = 1'b1;
          end
        end
        S_HALF: begin
          if (data_edge) begin
            if (int_q >= HMIN && int_q <= HMAX) begin
              emit     = 1'b1;
              emit_val = 1'b1;
              state_d  = S_DECODE;
            end else begin
              err_d   = 1'b1;
              state_d = S_FLUSH;
            end
          end else if (timeout) begin
            state_d = S_FLUSH;
            if (cnt_q == '0) err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (emit) begin
      bit_valid_d = 1'b1;
      bit_out_d   = emit_val;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      int_q       <= '0;
      // Treat the envelope as already active so a pulse that is in progress
      // out of reset is not reported; it must go inactive first.
      env_prev_q  <= 1'b1;
      start_ts_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
      pstart_q    <= 1'b0;
      pend_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      int_q       <= int_d;
      env_prev_q  <= env_prev_d;
      start_ts_q  <= start_ts_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      active_q    <= active_d;
      pstart_q    <= pstart_d;
      pend_q      <= pend_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
    end
  end

  assign bit_out      = bit_out_q;
  assign bit_valid    = bit_valid_q;
  assign pulse_active = active_q;
  assign pulse_start  = pstart_q;
  assign start_ts     = start_ts_q;
  assign pulse_end    = pend_q;
  assign bit_count    = cnt_q;
  assign pulse_error  = err_q;

endmodule
